uart_imem_loader: RTL and testbench

Upstream programming stage for the instruction memory: consumes the byte stream from the UART receiver, frames it into 32-bit little-endian words, and drives the memory's write port (WE/A/WD) one word at a time. Holds the core in reset while a program is loading. Reports completion or failure of the load.

---
 rtl/loader_pkg.sv | 22 ++
 rtl/loader_word_pack.sv | 47 ++++
 rtl/uart_imem_loader.sv | 200 ++++++++++++++++++++
 tb/tb_uart_imem_loader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : loader_pkg
//  Brief    : Shared states and constants for the UART instruction-memory loader.
//  Revision : 1.0
// ============================================================================
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    DATA  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_e;

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam logic [31:0] NOP_INSN  = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/loader_word_pack.sv
`default_nettype none
// ============================================================================
//  Module   : loader_word_pack
//  Brief    : Packs a byte stream LSB-first into 32-bit words.
//  Revision : 1.0
// ============================================================================
module loader_word_pack (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        byte_valid_i,
  input  logic        clear_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_ready_o
);

  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (clear_i) begin
      word_d = '0;
      idx_d  = '0;
    end else if (byte_valid_i) begin
      word_d[8*idx_q +: 8] = byte_i;
      idx_d                = idx_q + 2'd1;
    end
  end

  // The completed word includes the byte arriving this cycle.
  assign word_o       = word_d;
  assign word_ready_o = byte_valid_i && !clear_i && (idx_q == 2'd3);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : uart_imem_loader
//  Brief    : Frames UART bytes into words and writes them to instruction memory.
//             Optional inter-byte timeout enabled by macro LOADER_TIMEOUT_EN.
//  Revision : 1.0
// ============================================================================
module uart_imem_loader
  import loader_pkg::*;
#(
  parameter int MEM_WORDS      = 20,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        WE,
  output logic [31:0] A,
  output logic [31:0] WD,
  output logic        core_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int         IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [7:0] MAX_N = 8'(MEM_WORDS);

  state_e           state_q, state_d;
  logic [7:0]       count_q, count_d;
  logic [IDX_W-1:0] widx_q, widx_d;
  logic [7:0]       csum_q, csum_d;
  logic             we_q, we_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      wd_q, wd_d;
  logic             hold_q, hold_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             in_frame;
  logic             timeout;
  logic             pack_valid;
  logic             pack_clear;
  logic             word_ready;
  logic [31:0]      pack_word;
  logic             last_word;

  assign in_frame   = (state_q == COUNT) || (state_q == DATA) || (state_q == CHECK);
  assign pack_valid = rx_valid && (state_q == DATA);
  assign last_word  = (8'(widx_q) == (count_q - 8'd1));

  loader_word_pack u_pack (
    .clk_i        (CLK),
    .rst_n_i      (RST_N),
    .byte_valid_i (pack_valid),
    .clear_i      (pack_clear),
    .byte_i       (rx_data),
    .word_o       (pack_word),
    .word_ready_o (word_ready)
  );

`ifdef LOADER_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;

  // Reloads on every accepted byte; only advances while a frame is open.
  always_comb begin
    tmo_d = '0;
    if (in_frame && !rx_valid) begin
      tmo_d = tmo_q + 32'd1;
    end
  end

  assign timeout = in_frame && !rx_valid && (tmo_q == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout            = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    widx_d     = widx_q;
    csum_d     = csum_q;
    we_d       = 1'b0;
    a_d        = a_q;
    wd_d       = wd_q;
    hold_d     = hold_q;
    done_d     = done_q;
    err_d      = err_q;
    pack_clear = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d = COUNT;
          done_d  = 1'b0;
          err_d   = 1'b0;
          hold_d  = 1'b1;
        end
      end
      COUNT: begin
        if (timeout) begin
          state_d = ERR;
        end else if (rx_valid) begin
          if ((rx_data != 8'd0) && (rx_data <= MAX_N)) begin
            count_d    = rx_data;
            widx_d     = '0;
            csum_d     = '0;
            pack_clear = 1'b1;
            state_d    = DATA;
          end else begin
            state_d = ERR;
          end
        end
      end
      DATA: begin
        if (timeout) begin
          state_d = ERR;
        end else if (rx_valid) begin
          csum_d = csum_q ^ rx_data;
          if (word_ready) begin
            we_d = 1'b1;
            a_d  = 32'(widx_q) << 2;
            wd_d = pack_word;
            if (last_word) begin
              state_d = CHECK;
            end else begin
              widx_d = widx_q + IDX_W'(1);
            end
          end
        end
      end
      CHECK: begin
        if (timeout) begin
          state_d = ERR;
        end else if (rx_valid) begin
          state_d = (rx_data == csum_q) ? DONE : ERR;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // DONE and ERR each last one cycle, so these fire only on entry.
    if (state_d == DONE) begin
      done_d = 1'b1;
      hold_d = 1'b0;
    end
    if (state_d == ERR) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      count_q <= '0;
      widx_q  <= '0;
      csum_q  <= '0;
      we_q    <= 1'b0;
      a_q     <= '0;
      wd_q    <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      widx_q  <= widx_d;
      csum_q  <= csum_d;
      we_q    <= we_d;
      a_q     <= a_d;
      wd_q    <= wd_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign WE        = we_q;
  assign A         = a_q;
  assign WD        = wd_q;
  assign core_hold = hold_q;
  assign busy      = in_frame;
  assign done      = done_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_imem_loader
//  Brief    : Directed and random frame stimulus for uart_imem_loader.
//  Revision : 1.0
// ============================================================================
module tb_uart_imem_loader;
  import loader_pkg::*;

  localparam int MEM_WORDS = 20;
  localparam int TMO       = 100;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data  = 8'h00;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic        core_hold;
  logic        busy;
  logic        done;
  logic        err;

  int nchecks = 0;
  int nerrors = 0;

  logic [31:0] got_a[$];
  logic [31:0] got_d[$];
  logic [31:0] exp_a[$];
  logic [31:0] exp_d[$];
  logic [31:0] fw[$];
  logic        we_prev = 1'b0;

  uart_imem_loader #(
    .MEM_WORDS      (MEM_WORDS),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .WE        (we),
    .A         (a),
    .WD        (wd),
    .core_hold (core_hold),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Write-port monitor: records every write, and flags any multi-cycle strobe.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      nchecks++;
      assert (we_prev !== 1'b1) else begin
        nerrors++;
        $error("FAIL we_pulse observed=multi-cycle expected=single-cycle");
      end
      got_a.push_back(a);
      got_d.push_back(wd);
    end
    we_prev = we;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchecks++;
    assert (obs === expv) else begin
      nerrors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwr"}, 32'(got_a.size()), 32'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      chk($sformatf("%s_A%0d", tag, i), got_a[i], exp_a[i]);
      chk($sformatf("%s_WD%0d", tag, i), got_d[i], exp_d[i]);
    end
    got_a.delete();
    got_d.delete();
    exp_a.delete();
    exp_d.delete();
  endtask

  task automatic check_flags(input string tag, input logic e_done, input logic e_err,
                             input logic e_hold);
    chk({tag, "_done"}, 32'(done), 32'(e_done));
    chk({tag, "_err"}, 32'(err), 32'(e_err));
    chk({tag, "_hold"}, 32'(core_hold), 32'(e_hold));
    chk({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_WE"}, 32'(we), 32'h0);
    chk({tag, "_A"}, a, 32'h0);
    chk({tag, "_WD"}, wd, 32'h0);
    check_flags(tag, 1'b0, 1'b0, 1'b1);
  endtask

  // Sends SYNC, count, the words in fw LSB first and a checksum; the model's
  // expected writes are simply word i at byte address 4*i.
  task automatic send_frame(input string tag, input bit corrupt, input int max_gap);
    logic [7:0]  cs;
    logic [31:0] w;
    cs = 8'h00;
    send_byte(SYNC_BYTE);
    idle($urandom_range(0, max_gap));
    send_byte(8'(fw.size()));
    chk({tag, "_busy_in"}, 32'(busy), 32'h1);
    for (int i = 0; i < fw.size(); i++) begin
      w = fw[i];
      for (int k = 0; k < 4; k++) begin
        idle($urandom_range(0, max_gap));
        send_byte(w[8*k +: 8]);
        cs = cs ^ w[8*k +: 8];
      end
      exp_a.push_back(32'(i) * 32'd4);
      exp_d.push_back(w);
    end
    idle($urandom_range(0, max_gap));
    send_byte(corrupt ? (cs ^ 8'h11) : cs);
    check_flags(tag, !corrupt, corrupt, corrupt);
    check_writes(tag);
    idle(1);
  endtask

  initial begin
    // Reset state
    idle(3);
    check_reset_state("reset");
    rst_n = 1'b1;
    idle(2);

    // Good 2-word load, back-to-back bytes
    fw = '{NOP_INSN, 32'h0010_0093};
    send_frame("good2", 1'b0, 0);

    // Same frame, bad checksum (final byte 0x81)
    fw = '{NOP_INSN, 32'h0010_0093};
    send_frame("badcs", 1'b1, 0);

    // Count out of range
    send_byte(SYNC_BYTE);
    send_byte(8'h00);
    check_flags("cnt0", 1'b0, 1'b1, 1'b1);
    check_writes("cnt0");
    idle(1);
    send_byte(SYNC_BYTE);
    send_byte(8'(MEM_WORDS + 1));
    check_flags("cnt21", 1'b0, 1'b1, 1'b1);
    check_writes("cnt21");
    idle(1);

    // Largest legal count
    fw.delete();
    for (int i = 0; i < MEM_WORDS; i++) fw.push_back($urandom);
    send_frame("max", 1'b0, 1);

    // Noise before sync, then an embedded 0xA5 treated as data
    send_byte(8'h00);
    send_byte(8'hFF);
    chk("noise_busy", 32'(busy), 32'h0);
    fw = '{32'h0000_00A5};
    send_frame("embsync", 1'b0, 0);

    // Reset mid-frame after three data bytes
    send_byte(SYNC_BYTE);
    send_byte(8'h02);
    send_byte(8'h13);
    send_byte(8'h00);
    send_byte(8'h00);
    rst_n = 1'b0;
    idle(1);
    check_reset_state("midrst");
    check_writes("midrst");
    rst_n = 1'b1;
    idle(1);
    fw = '{NOP_INSN, 32'h0010_0093};
    send_frame("afterrst", 1'b0, 0);

`ifdef LOADER_TIMEOUT_EN
    send_byte(SYNC_BYTE);
    send_byte(8'h01);
    send_byte(8'h13);
    idle(TMO);
    check_flags("tmo", 1'b0, 1'b1, 1'b1);
    check_writes("tmo");
    idle(1);
`else
    // Without the timeout the loader simply waits for the rest of the frame
    send_byte(SYNC_BYTE);
    send_byte(8'h01);
    send_byte(8'h13);
    idle(150);
    chk("wait_busy", 32'(busy), 32'h1);
    chk("wait_err", 32'(err), 32'h0);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h13);
    exp_a.push_back(32'h0);
    exp_d.push_back(NOP_INSN);
    check_flags("wait", 1'b1, 1'b0, 1'b0);
    check_writes("wait");
    idle(1);
`endif

    // Random frames with random gaps and occasional corrupted checksums
    for (int f = 0; f < 10; f++) begin
      int n;
      bit bad;
      n   = $urandom_range(1, MEM_WORDS);
      bad = ($urandom_range(0, 3) == 0);
      fw.delete();
      for (int i = 0; i < n; i++) begin
        fw.push_back(($urandom_range(0, 3) == 0) ? 32'hA5A5_A5A5 : 32'($urandom));
      end
      send_frame($sformatf("rnd%0d", f), bad, 2);
    end

    $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
    $finish;
  end

endmodule
`default_nettype wire
